// File: rtl/fib_engine_if.sv
// Request/result bundle for fib_engine: strobe and index in, status and result out.
interface fib_engine_if;
    logic       stb;
    logic [7:0] n;
    logic       busy;
    logic       done;
    logic [7:0] fib;
    logic       ovf;

    modport master (output stb, n, input busy, done, fib, ovf);
    modport slave  (input stb, n, output busy, done, fib, ovf);
endinterface

// File: rtl/fib_engine.sv
// Iterative F(n) mod 256 engine, one addition per clock.
// Define FIB_OVF_EN to report whether F(n) exceeded 255; otherwise ovf is tied low.
module fib_engine (
    input  logic         clk,
    input  logic         rst,
    fib_engine_if.slave  bus
);
    typedef enum logic {IDLE, CALC} state_t;

    state_t     state, state_nx;
    logic [7:0] a, b, cnt, fib_q;
    logic [7:0] a_nx, b_nx, cnt_nx, fib_nx;
    logic       busy_q, done_q, busy_nx, done_nx;
    logic [7:0] sum;

`ifdef FIB_OVF_EN
    logic carry, acc, acc_nx, ovf_q, ovf_nx;
    assign {carry, sum} = {1'b0, a} + {1'b0, b};
`else
    assign sum = a + b;
`endif

    always_comb begin
        state_nx = state;
        a_nx     = a;
        b_nx     = b;
        cnt_nx   = cnt;
        fib_nx   = fib_q;
        busy_nx  = busy_q;
        done_nx  = 1'b0;
`ifdef FIB_OVF_EN
        acc_nx   = acc;
        ovf_nx   = ovf_q;
`endif
        case (state)
            IDLE: begin
                if (bus.stb) begin
                    a_nx     = 8'd0;
                    b_nx     = 8'd1;
                    cnt_nx   = bus.n;
                    busy_nx  = 1'b1;
                    state_nx = CALC;
`ifdef FIB_OVF_EN
                    acc_nx   = 1'b0;
`endif
                end
            end
            CALC: begin
                if (cnt > 8'd1) begin
                    a_nx   = b;
                    b_nx   = sum;
                    cnt_nx = cnt - 8'd1;
`ifdef FIB_OVF_EN
                    acc_nx = acc | carry;
`endif
                end else begin
                    // cnt==0 only happens for n=0, whose result is 0
                    fib_nx   = (cnt == 8'd1) ? b : 8'd0;
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
`ifdef FIB_OVF_EN
                    ovf_nx   = acc;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a      <= 8'd0;
            b      <= 8'd1;
            cnt    <= 8'd0;
            fib_q  <= 8'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            a      <= a_nx;
            b      <= b_nx;
            cnt    <= cnt_nx;
            fib_q  <= fib_nx;
            busy_q <= busy_nx;
            done_q <= done_nx;
        end
    end

`ifdef FIB_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            acc   <= acc_nx;
            ovf_q <= ovf_nx;
        end
    end
    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.fib  = fib_q;
endmodule

// File: tb/tb_fib_engine.sv
// Scoreboard bench for fib_engine: expected results queued at request time, checked on done.
module tb_fib_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fib_engine_if bus ();
    fib_engine dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [7:0] fib;
        logic       ovf;
        int         len;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   busy_cnt = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: exact F(n) saturated at 1000 for the overflow test, mod 256 for the value
    function automatic exp_t model(input int n);
        exp_t e;
        int mx = 0, my = 1, cx = 0, cy = 1, t;
        for (int i = 0; i < n; i++) begin
            t = (mx + my) % 256; mx = my; my = t;
            t = cx + cy; cx = cy; cy = (t > 1000) ? 1000 : t;
        end
        e.fib = mx[7:0];
`ifdef FIB_OVF_EN
        e.ovf = (cx > 255);
`else
        e.ovf = 1'b0;
`endif
        e.len = (n == 0) ? 1 : n;
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        if (rst) busy_cnt = 0;
        else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                chk("done_with_busy_low", bus.busy, 0);
                if (q.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("fib", bus.fib, e.fib);
                    chk("ovf", bus.ovf, e.ovf);
                    chk("busy_len", busy_cnt, e.len);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic req(input int n, input bit push);
        @(negedge clk);
        bus.stb = 1'b1;
        bus.n   = n[7:0];
        if (push) q.push_back(model(n));
        @(negedge clk);
        bus.stb = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 1000; i++) begin
            if (!bus.busy) break;
            @(negedge clk);
        end
        if (i == 1000) chk("timeout", 1, 0);
    endtask

    initial begin
        int idle;
        bus.stb = 1'b0;
        bus.n   = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_fib",  bus.fib, 0);
        chk("rst_ovf",  bus.ovf, 0);
        rst = 1'b0;

        req(0, 1); wait_idle();
        for (int n = 1; n <= 10; n++) begin
            req(n, 1); wait_idle();
        end
        req(13, 1); wait_idle();
        req(14, 1); wait_idle();
        req(255, 1); wait_idle();

        // request during CALC must be dropped
        req(10, 1);
        repeat (3) @(negedge clk);
        bus.stb = 1'b1; bus.n = 8'd3;
        @(negedge clk);
        bus.stb = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("ignored_fib", bus.fib, 55);

        // stb held high: accepted at edges 0, 3, 6
        @(negedge clk);
        bus.stb = 1'b1; bus.n = 8'd2;
        repeat (3) q.push_back(model(2));
        idle = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!bus.busy) idle++;
        end
        bus.stb = 1'b0;
        chk("held_idle_cycles", idle, 2);
        wait_idle();
        @(negedge clk);

        // reset aborts a long computation
        req(200, 0);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_fib",  bus.fib, 0);
        chk("abort_done", bus.done, 0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", bus.done, 0);
        req(5, 1); wait_idle();
        @(negedge clk);
        chk("post_abort_fib", bus.fib, 5);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fib_engine.md
FIB_ENGINE -- requirements
Module: fib_engine

Interface
REQ-001 SHALL have `clk`, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have `rst`, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-003 SHALL have `stb`, input, 1 bit: request strobe, sampled on rising `clk`.
REQ-004 SHALL have `n`, input, 8 bits: Fibonacci index, sampled with `stb`.
REQ-005 SHALL have `busy`, output, 1 bit: computation in progress (registered).
REQ-006 SHALL have `done`, output, 1 bit: one-cycle pulse when a result is written.
REQ-007 SHALL have `fib`, output, 8 bits: last computed F(n) mod 256 (registered).
REQ-008 SHALL have `ovf`, output, 1 bit: overflow flag of last computation (see Configuration).

Function
REQ-009 SHALL implement FSM states IDLE and CALC; IDLE is the only state that accepts requests.
REQ-010 In IDLE with `stb`=1 at an edge, SHALL load a=0, b=1, cnt=`n`, clear the internal ovf accumulator, enter CALC, and drive `busy`=1 from that edge.
REQ-011 In CALC with cnt>1, SHALL per edge compute a<=b, b<=(a+b) mod 256, cnt<=cnt-1.
REQ-012 In CALC with cnt==1, SHALL write `fib`<=b, pulse `done`=1 for one cycle, drive `busy`<=0, and return to IDLE.
REQ-013 In CALC with cnt==0, SHALL write `fib`<=0, pulse `done`, drive `busy`<=0, and return to IDLE.
REQ-014 `busy` SHALL stay high for exactly max(n,1) cycles; `done` SHALL assert on the same edge at which `busy` falls.
REQ-015 `stb` SHALL be ignored while `busy`=1; there is no queueing, and `n` changes during CALC have no effect.
REQ-016 `fib` and `ovf` SHALL hold their previous values during CALC and update only on the `done` edge.
REQ-017 `stb` in the same cycle as `done` SHALL be ignored; a new request is accepted on the next IDLE edge.
REQ-018 `stb` held high continuously SHALL start back-to-back computations, each separated by one IDLE cycle.
REQ-019 `n`=255 SHALL complete normally (255 busy cycles) with the wrapped 8-bit result.

Reset
REQ-020 `rst`=1 at an edge SHALL force IDLE with `busy`=0, `done`=0, `fib`=0, `ovf`=0, a=0, b=1, cnt=0.
REQ-021 Reset SHALL take priority over `stb` and over an in-progress CALC; an aborted computation produces no `done` and leaves `fib` at 0.

Configuration
REQ-022 Macro `FIB_OVF_EN` defined: the engine SHALL set the accumulator when any b-update addition carries out of bit 7, and copy it to `ovf` on the `done` edge (F(n) exceeds 255).
REQ-023 Macro `FIB_OVF_EN` undefined: the engine SHALL tie `ovf` to 0 and SHALL omit the accumulator logic; all other behaviour is identical.

Verification
REQ-024 Reset then `stb` with n=0 -> `busy` high for 1 cycle, `done` pulse, `fib`=0, `ovf`=0.
REQ-025 Sequence n=1..10, one 1-cycle `stb` each, waiting for `busy`=0 -> `fib`=1,1,2,3,5,8,13,21,34,55; n=10 shows exactly 10 busy cycles.
REQ-026 n=13 -> `fib`=233, `ovf`=0; then n=14 -> `fib`=121, `ovf`=1 with FIB_OVF_EN, `ovf`=0 without.
REQ-027 n=10 started, then `stb` with n=3 at busy cycle 4 -> ignored; `fib`=55 and `busy` duration is unchanged at 10 cycles.
REQ-028 n=200 started, `rst` asserted at busy cycle 50 -> next cycle `busy`=0, `fib`=0, no `done`; a following n=5 request gives `fib`=5.
REQ-029 `stb` held high with n=2 for 8 cycles -> repeated `done` pulses, each with `fib`=1, and one IDLE cycle between computations.
